ro_puf_engine: RTL
==================

RO_PUF_ENGINE -- requirements
Module: ro_puf_engine

Interface
REQ-001 SHALL have parameter N_RO, default 16, meaning ring oscillators per bank (two banks, A and B; power of two, at least 2).
REQ-002 SHALL have parameter SEL_W, default $clog2(N_RO), meaning selector width per bank.
REQ-003 SHALL have parameter CNT_W, default 24, meaning edge-counter width per bank.
REQ-004 SHALL have parameter WIN_CYC, default 65536, meaning measurement window length in clk cycles (at least 1).
REQ-005 SHALL have parameter SETTLE_CYC, default 4, meaning clk cycles between oscillator disable and compare (at least 2).
REQ-006 SHALL have parameter RESP_BITS, default 8, meaning response bits (pair comparisons) per request.
REQ-007 SHALL have parameter STAGES, default 15, meaning inverting stages per oscillator (odd).
REQ-008 SHALL have port clk, input, 1 bit, meaning system clock.
REQ-009 SHALL have port rst, input, 1 bit, meaning asynchronous active-high reset.
REQ-010 SHALL have port req_valid, input, 1 bit, meaning a challenge is offered.
REQ-011 SHALL have port req_ready, output, 1 bit, meaning the engine accepts a challenge.
REQ-012 SHALL have port challenge, input, RESP_BITS*2*SEL_W bits, meaning the pair selectors.
REQ-013 SHALL have port resp_valid, output, 1 bit, meaning the response is available.
REQ-014 SHALL have port resp_ready, input, 1 bit, meaning the consumer takes the response.
REQ-015 SHALL have port response, output, RESP_BITS bits, meaning the PUF response.
REQ-016 SHALL have port tie, output, RESP_BITS bits, meaning the corresponding response bit came from equal counts.
REQ-017 SHALL have port busy, output, 1 bit, meaning a measurement is in progress.

Function
REQ-018 Handshake SHALL be valid/ready; a transfer occurs on a clk edge with valid and ready both high.
REQ-019 req_ready SHALL be 1 only in IDLE; challenge SHALL be latched at acceptance and external changes afterwards SHALL be ignored.
REQ-020 FSM states SHALL be IDLE, CLEAR, RUN, SETTLE, COMPARE, DONE.
REQ-021 Transitions: IDLE->CLEAR on acceptance; CLEAR->RUN after 1 cycle; RUN->SETTLE after WIN_CYC cycles; SETTLE->COMPARE after SETTLE_CYC cycles; COMPARE->CLEAR when bit index < RESP_BITS-1, else ->DONE; DONE->IDLE on resp_ready.
REQ-022 Bit i SHALL use bank-A select challenge[i*2*SEL_W +: SEL_W] and bank-B select challenge[i*2*SEL_W+SEL_W +: SEL_W].
REQ-023 Only the two selected oscillators SHALL be enabled, and only during RUN; all others SHALL be held stopped.
REQ-024 Counters SHALL be cleared during CLEAR, SHALL increment on each rising edge of the selected oscillator, and SHALL saturate at all-ones.
REQ-025 COMPARE SHALL set response[i]=0 and tie[i]=0 if cntA>cntB, response[i]=1 and tie[i]=0 if cntA<cntB, and response[i]=0 and tie[i]=1 if cntA==cntB (including both saturated).
REQ-026 resp_valid SHALL rise exactly RESP_BITS*(WIN_CYC+SETTLE_CYC+2) clk edges after the acceptance edge.
REQ-027 In DONE, resp_valid, response and tie SHALL be held stable until resp_ready; resp_valid SHALL drop on the transfer edge.
REQ-028 busy SHALL be 1 in CLEAR, RUN, SETTLE and COMPARE, and 0 in IDLE and DONE.
REQ-029 req_valid outside IDLE SHALL have no effect; a new request is accepted no earlier than the cycle after the DONE->IDLE transfer.

Reset
REQ-030 rst SHALL force IDLE, clear both counters and the bit index, and stop all oscillators at any point, including mid-RUN.
REQ-031 After rst: req_ready=1, resp_valid=0, busy=0, response=0, tie=0; a partial result SHALL never be presented.

Structure
REQ-032 Package ro_puf_pkg SHALL hold the FSM state enum and default parameter constants.
REQ-033 Sub-module ro_cell (parameter STAGES; ports enable, out; NAND-gated loop; keep/dont_touch) SHALL be instantiated 2*N_RO times.
REQ-034 Bank counters SHALL be clocked by the selected oscillator, with asynchronous clear driven from the clk domain; clk-domain reads SHALL occur only in COMPARE, after SETTLE_CYC.

Verification
REQ-035 Bench SHALL use a behavioural ro_cell with a per-instance period.
REQ-036 Scenario: N_RO=4, WIN_CYC=100, SETTLE_CYC=4, RESP_BITS=1; A0 period 2 ns, B0 period 3 ns, clk 10 ns, challenge=0 -> response=0, tie=0, resp_valid at edge 106.
REQ-037 Scenario: swap the periods -> response=1, tie=0.
REQ-038 Scenario: equal periods with aligned start -> response=0, tie=1.
REQ-039 Scenario: RESP_BITS=4, challenge selecting pairs (0,1)(1,0)(2,3)(3,2) with distinct periods -> each bit matches the period ordering, and resp_valid at 4*106.
REQ-040 Scenario: rst asserted mid-RUN -> IDLE next edge, outputs at reset values, all oscillators stopped; a new request then completes normally.
REQ-041 Scenario: resp_ready held 0 for 20 cycles in DONE -> outputs stable and req_ready=0; req_valid pulses ignored.

Source files
------------

// File: rtl/ro_puf_pkg.sv
// ro_puf_pkg: FSM state encoding and default sizing for the RO PUF engine
package ro_puf_pkg;
  typedef enum logic [2:0] {IDLE, CLEAR, RUN, SETTLE, COMPARE, DONE} state_t;
  localparam int DEF_N_RO       = 16;
  localparam int DEF_CNT_W      = 24;
  localparam int DEF_WIN_CYC    = 65536;
  localparam int DEF_SETTLE_CYC = 4;
  localparam int DEF_RESP_BITS  = 8;
  localparam int DEF_STAGES     = 15;
endpackage

// File: rtl/ro_puf_engine_ro_cell.sv
// ro_cell: NAND-gated ring oscillator; the loop is stopped (out high) while enable is low
module ro_cell #(
  parameter int STAGES = 15
) (
  input  logic enable,
  output logic out
);
  (* keep = "true", dont_touch = "true" *) logic [STAGES-1:0] s;
  assign s[0] = ~(enable & out);
  for (genvar i = 1; i < STAGES; i++) begin : g_inv
    assign s[i] = ~s[i-1];
  end
  assign out = s[STAGES-1];
endmodule

// File: rtl/ro_puf_engine.sv
// ro_puf_engine: ring-oscillator PUF, one response bit per challenge-selected A/B oscillator pair
module ro_puf_engine
  import ro_puf_pkg::*;
#(
  parameter int N_RO       = DEF_N_RO,
  parameter int SEL_W      = $clog2(N_RO),
  parameter int CNT_W      = DEF_CNT_W,
  parameter int WIN_CYC    = DEF_WIN_CYC,
  parameter int SETTLE_CYC = DEF_SETTLE_CYC,
  parameter int RESP_BITS  = DEF_RESP_BITS,
  parameter int STAGES     = DEF_STAGES
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         req_valid,
  output logic                         req_ready,
  input  logic [RESP_BITS*2*SEL_W-1:0] challenge,
  output logic                         resp_valid,
  input  logic                         resp_ready,
  output logic [RESP_BITS-1:0]         response,
  output logic [RESP_BITS-1:0]         tie,
  output logic                         busy
);
  localparam int CH_W  = RESP_BITS * 2 * SEL_W;
  localparam int IDX_W = RESP_BITS > 1 ? $clog2(RESP_BITS) : 1;
  localparam int TMR_W = $clog2(WIN_CYC > SETTLE_CYC ? WIN_CYC : SETTLE_CYC) + 1;
  state_t              state;
  logic [CH_W-1:0]     chal;
  logic [IDX_W-1:0]    idx;
  logic [TMR_W-1:0]    tmr;
  logic [N_RO-1:0]     en_a, en_b, ro_a, ro_b;
  logic [SEL_W-1:0]    sel_a, sel_b;
  logic [CNT_W-1:0]    cnt_a, cnt_b;
  logic [RESP_BITS-1:0] acc_r, acc_t, res_nx, tie_nx;
  logic                clr_q, clr, osc_a, osc_b;

  for (genvar i = 0; i < N_RO; i++) begin : g_ro
    ro_cell #(.STAGES(STAGES)) u_a (.enable(en_a[i]), .out(ro_a[i]));
    ro_cell #(.STAGES(STAGES)) u_b (.enable(en_b[i]), .out(ro_b[i]));
  end

  // Gating by the enables keeps stopped cells and selector changes off the counter clocks
  assign osc_a = |(ro_a & en_a);
  assign osc_b = |(ro_b & en_b);
  assign clr   = rst | clr_q;
  assign sel_a = chal[idx*2*SEL_W +: SEL_W];
  assign sel_b = chal[idx*2*SEL_W+SEL_W +: SEL_W];

  always_ff @(posedge osc_a or posedge clr)
    if (clr) cnt_a <= '0;
    else if (cnt_a != '1) cnt_a <= cnt_a + 1'b1;

  always_ff @(posedge osc_b or posedge clr)
    if (clr) cnt_b <= '0;
    else if (cnt_b != '1) cnt_b <= cnt_b + 1'b1;

  always_comb begin
    res_nx      = acc_r;
    tie_nx      = acc_t;
    res_nx[idx] = cnt_a < cnt_b;
    tie_nx[idx] = cnt_a == cnt_b;
  end

  // Counters are only sampled in COMPARE, SETTLE_CYC cycles after the oscillators stopped
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state      <= IDLE;
      chal       <= '0;
      idx        <= '0;
      tmr        <= '0;
      en_a       <= '0;
      en_b       <= '0;
      clr_q      <= 1'b0;
      acc_r      <= '0;
      acc_t      <= '0;
      response   <= '0;
      tie        <= '0;
      resp_valid <= 1'b0;
      req_ready  <= 1'b1;
      busy       <= 1'b0;
    end else begin
      case (state)
        IDLE:
          if (req_valid) begin
            state     <= CLEAR;
            chal      <= challenge;
            idx       <= '0;
            clr_q     <= 1'b1;
            req_ready <= 1'b0;
            busy      <= 1'b1;
          end
        CLEAR: begin
          state <= RUN;
          clr_q <= 1'b0;
          tmr   <= TMR_W'(WIN_CYC - 1);
          en_a  <= N_RO'(1) << sel_a;
          en_b  <= N_RO'(1) << sel_b;
        end
        RUN:
          if (tmr == '0) begin
            state <= SETTLE;
            en_a  <= '0;
            en_b  <= '0;
            tmr   <= TMR_W'(SETTLE_CYC - 1);
          end else tmr <= tmr - 1'b1;
        SETTLE:
          if (tmr == '0) state <= COMPARE;
          else tmr <= tmr - 1'b1;
        COMPARE: begin
          acc_r <= res_nx;
          acc_t <= tie_nx;
          if (idx == IDX_W'(RESP_BITS - 1)) begin
            state      <= DONE;
            response   <= res_nx;
            tie        <= tie_nx;
            resp_valid <= 1'b1;
            busy       <= 1'b0;
          end else begin
            state <= CLEAR;
            idx   <= idx + 1'b1;
            clr_q <= 1'b1;
          end
        end
        DONE:
          if (resp_ready) begin
            state      <= IDLE;
            response   <= '0;
            tie        <= '0;
            resp_valid <= 1'b0;
            req_ready  <= 1'b1;
          end
        default: state <= IDLE;
      endcase
    end
endmodule
